tile_color_decode: RTL and testbench

Inverse of the tile-colour encoder. Consumes the rendered board as a raster pixel stream, samples the centre pixel of every tile, and decodes each 24-bit colour back to the tile's neighbour count. Each result is emitted as a (tile index, count) record through a 2-entry output FIFO with valid/ready handshaking. Used for display self-check and screen-readback of the board.

---
 rtl/tile_color_decode.sv | 212 +++++++++++++++++++++
 tb/tb_tile_color_decode.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tile_color_decode.sv
// -----------------------------------------------------------------------------
// tile_color_decode
//
// Turns a rendered board image back into tile neighbour counts. The block
// takes a raster pixel stream and samples the centre pixel of every tile.
// It decodes that pixel's 24-bit colour back to a count. Each result leaves
// as a (tile index, count) record through a 2-entry output FIFO.
//
// Parameters:
//   COLS, ROWS  tiles per row / per column
//   TILE_PX     pixel edge of one square tile (even, >= 2)
//   IW          tile index width
//
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   px_valid     pixel present
//   px_ready     pixel accepted when px_valid && px_ready (FIFO not full)
//   px_sof       start of frame, marks the accepted pixel as (0,0)
//   px_color     24-bit RGB pixel
//   tile_valid   output record present
//   tile_ready   downstream accepts record
//   tile_idx     tile_row*COLS + tile_col
//   tile_count   decoded count (0-8, F = hidden, E = unknown colour)
//   frame_done   one-cycle pulse after the last pixel of a frame
//   sync_err     one-cycle pulse after px_sof arrived mid-frame
//   err_cnt      saturating count of unmatched sample colours
//
// Handshake: both ports use strict valid/ready semantics. A transfer happens
// on a rising clock edge where valid && ready are both high. The producer
// holds valid and its payload stable until that transfer. ready may depend
// on internal state only, never combinationally on valid.
// -----------------------------------------------------------------------------
module tile_color_decode #(
    parameter int COLS    = 8,
    parameter int ROWS    = 8,
    parameter int TILE_PX = 16,
    parameter int IW      = $clog2(ROWS*COLS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          px_valid,
    output logic          px_ready,
    input  logic          px_sof,
    input  logic [23:0]   px_color,
    output logic          tile_valid,
    input  logic          tile_ready,
    output logic [IW-1:0] tile_idx,
    output logic [3:0]    tile_count,
    output logic          frame_done,
    output logic          sync_err,
    output logic [7:0]    err_cnt
);

    // The pixel position is kept as (tile, offset-in-tile) pairs per axis.
    // Sample detection and the tile index then need no divide or modulo.
    localparam int TXW = (COLS    > 1) ? $clog2(COLS)    : 1;
    localparam int TYW = (ROWS    > 1) ? $clog2(ROWS)    : 1;
    localparam int SW  = (TILE_PX > 1) ? $clog2(TILE_PX) : 1;

    localparam logic [TXW-1:0] TX_LAST = TXW'(COLS - 1);
    localparam logic [TYW-1:0] TY_LAST = TYW'(ROWS - 1);
    localparam logic [SW-1:0]  S_LAST  = SW'(TILE_PX - 1);
    localparam logic [SW-1:0]  S_HALF  = SW'(TILE_PX / 2);

    logic [TXW-1:0] tx_q;
    logic [TYW-1:0] ty_q;
    logic [SW-1:0]  sx_q;
    logic [SW-1:0]  sy_q;

    // Position of the pixel being accepted. px_sof forces it to (0,0).
    logic [TXW-1:0] e_tx;
    logic [TYW-1:0] e_ty;
    logic [SW-1:0]  e_sx;
    logic [SW-1:0]  e_sy;

    logic [TXW-1:0] tx_d;
    logic [TYW-1:0] ty_d;
    logic [SW-1:0]  sx_d;
    logic [SW-1:0]  sy_d;

    logic           acc;
    logic           at_origin;
    logic           is_sample;
    logic           frame_end;
    logic           push;
    logic           pop;

    logic [IW-1:0]  cur_idx;
    logic [3:0]     dec_cnt;

    // 2-entry FIFO
    logic [IW-1:0]  mem_idx [2];
    logic [3:0]     mem_cnt [2];
    logic           wr_ptr;
    logic           rd_ptr;
    logic [1:0]     occ;

    assign px_ready   = (occ != 2'd2);
    assign tile_valid = (occ != 2'd0);
    assign tile_idx   = mem_idx[rd_ptr];
    assign tile_count = mem_cnt[rd_ptr];

    assign acc       = px_valid && px_ready;
    assign pop       = tile_valid && tile_ready;
    assign at_origin = (tx_q == '0) && (ty_q == '0) && (sx_q == '0) && (sy_q == '0);

    assign e_tx = px_sof ? '0 : tx_q;
    assign e_ty = px_sof ? '0 : ty_q;
    assign e_sx = px_sof ? '0 : sx_q;
    assign e_sy = px_sof ? '0 : sy_q;

    assign is_sample = (e_sx == S_HALF) && (e_sy == S_HALF);
    assign push      = acc && is_sample;
    assign frame_end = (e_sx == S_LAST) && (e_tx == TX_LAST) &&
                       (e_sy == S_LAST) && (e_ty == TY_LAST);
    assign cur_idx   = IW'(e_ty) * IW'(COLS) + IW'(e_tx);

    // Advance the raster position past the accepted pixel.
    always_comb begin
        tx_d = e_tx;
        ty_d = e_ty;
        sx_d = e_sx + SW'(1);
        sy_d = e_sy;
        if (e_sx == S_LAST) begin
            sx_d = '0;
            if (e_tx == TX_LAST) begin
                tx_d = '0;
                if (e_sy == S_LAST) begin
                    sy_d = '0;
                    ty_d = (e_ty == TY_LAST) ? '0 : e_ty + TYW'(1);
                end else begin
                    sy_d = e_sy + SW'(1);
                end
            end else begin
                tx_d = e_tx + TXW'(1);
            end
        end
    end

    // Colour decode. Only an exact 24-bit match is accepted.
    always_comb begin
        dec_cnt = 4'hE;
        case (px_color)
            24'hFFFFFF: dec_cnt = 4'h0;
            24'hFAFFA6: dec_cnt = 4'h1;
            24'hFF6F00: dec_cnt = 4'h2;
            24'h2FFF00: dec_cnt = 4'h3;
            24'h00FFE1: dec_cnt = 4'h4;
            24'h00B3FF: dec_cnt = 4'h5;
            24'h9382C2: dec_cnt = 4'h6;
            24'hFF00EE: dec_cnt = 4'h7;
            24'h34003B: dec_cnt = 4'h8;
            24'hA6A6A6: dec_cnt = 4'hF;
            default:    dec_cnt = 4'hE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_q <= '0;
            ty_q <= '0;
            sx_q <= '0;
            sy_q <= '0;
        end else if (acc) begin
            tx_q <= tx_d;
            ty_q <= ty_d;
            sx_q <= sx_d;
            sy_q <= sy_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_done <= 1'b0;
            sync_err   <= 1'b0;
            err_cnt    <= 8'd0;
        end else begin
            frame_done <= acc && frame_end;
            sync_err   <= acc && px_sof && !at_origin;
            if (push && (dec_cnt == 4'hE) && (err_cnt != 8'hFF))
                err_cnt <= err_cnt + 8'd1;
        end
    end

    // FIFO. A push never targets the head entry while it is valid, so the
    // output payload holds still during backpressure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_idx[0] <= '0;
            mem_idx[1] <= '0;
            mem_cnt[0] <= '0;
            mem_cnt[1] <= '0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            occ        <= 2'd0;
        end else begin
            if (push) begin
                mem_idx[wr_ptr] <= cur_idx;
                mem_cnt[wr_ptr] <= dec_cnt;
                wr_ptr          <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

endmodule

// File: tb/tb_tile_color_decode.sv
// -----------------------------------------------------------------------------
// Bench for tile_color_decode on a 5x2 board with 4-pixel tiles (20x8 frame).
// A driver task pushes expected records when a sample pixel is accepted. A
// negedge monitor pops and compares them as the DUT hands records out.
// -----------------------------------------------------------------------------
module tb_tile_color_decode;

    localparam int COLS = 5;
    localparam int ROWS = 2;
    localparam int TP   = 4;
    localparam int IW   = 4;
    localparam int W    = COLS * TP;
    localparam int H    = ROWS * TP;
    localparam int NPIX = W * H;

    logic          clk;
    logic          rst;
    logic          px_valid;
    logic          px_ready;
    logic          px_sof;
    logic [23:0]   px_color;
    logic          tile_valid;
    logic          tile_ready;
    logic [IW-1:0] tile_idx;
    logic [3:0]    tile_count;
    logic          frame_done;
    logic          sync_err;
    logic [7:0]    err_cnt;

    tile_color_decode #(.COLS(COLS), .ROWS(ROWS), .TILE_PX(TP), .IW(IW)) dut (
        .clk        (clk),
        .rst        (rst),
        .px_valid   (px_valid),
        .px_ready   (px_ready),
        .px_sof     (px_sof),
        .px_color   (px_color),
        .tile_valid (tile_valid),
        .tile_ready (tile_ready),
        .tile_idx   (tile_idx),
        .tile_count (tile_count),
        .frame_done (frame_done),
        .sync_err   (sync_err),
        .err_cnt    (err_cnt)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    logic [IW+3:0] exp_q [$];
    int            checks;
    int            errors;
    int            rec_seen;
    bit            mon_en;
    int            mx;
    int            my;
    int            exp_err;
    logic [23:0]   fcol [COLS*ROWS];
    logic [23:0]   ref_col [COLS*ROWS] = '{24'hFFFFFF, 24'hFAFFA6, 24'hFF6F00,
                                           24'h2FFF00, 24'h00FFE1, 24'h00B3FF,
                                           24'h9382C2, 24'hFF00EE, 24'h34003B,
                                           24'hA6A6A6};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] model_decode(input logic [23:0] c);
        case (c)
            24'hFFFFFF: return 4'h0;
            24'hFAFFA6: return 4'h1;
            24'hFF6F00: return 4'h2;
            24'h2FFF00: return 4'h3;
            24'h00FFE1: return 4'h4;
            24'h00B3FF: return 4'h5;
            24'h9382C2: return 4'h6;
            24'hFF00EE: return 4'h7;
            24'h34003B: return 4'h8;
            24'hA6A6A6: return 4'hF;
            default:    return 4'hE;
        endcase
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (!rst && mon_en) begin
            chk("tile_valid", tile_valid, exp_q.size() != 0);
            if (tile_valid && tile_ready) begin
                rec_seen++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $error("FAIL unexpected_record got %0h expected none", {tile_idx, tile_count});
                end else begin
                    chk("record", {tile_idx, tile_count}, exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Offers one pixel until it is accepted. Each cycle the bench model is
    // advanced and the registered outputs are checked.
    task automatic drive_px(input logic [23:0] c, input logic s);
        logic acc;
        bit   exp_fd;
        bit   exp_se;
        int   waits;
        px_valid = 1'b1;
        px_color = c;
        px_sof   = s;
        waits    = 0;
        do begin
            @(negedge clk);
            acc = px_ready;
            @(posedge clk);
            #1;
            exp_fd = 0;
            exp_se = 0;
            if (acc) begin
                if (s) begin
                    if (mx != 0 || my != 0) exp_se = 1;
                    mx = 0;
                    my = 0;
                end
                if ((mx % TP) == TP/2 && (my % TP) == TP/2) begin
                    logic [3:0] d;
                    d = model_decode(c);
                    exp_q.push_back({IW'((my/TP)*COLS + mx/TP), d});
                    if (d == 4'hE && exp_err < 255) exp_err++;
                end
                if (mx == W-1) begin
                    mx = 0;
                    if (my == H-1) begin
                        my = 0;
                        exp_fd = 1;
                    end else begin
                        my++;
                    end
                end else begin
                    mx++;
                end
            end
            chk("frame_done", frame_done, exp_fd);
            chk("sync_err", sync_err, exp_se);
            chk("err_cnt", err_cnt, exp_err);
            chk("px_ready", px_ready, exp_q.size() < 2);
            waits++;
        end while (!acc && waits < 1000);
        if (!acc) begin
            checks++;
            errors++;
            $error("FAIL px_accept_timeout got stalled expected accept");
        end
        px_valid = 1'b0;
        px_sof   = 1'b0;
    endtask

    task automatic drive_frame(input int npix, input bit sof0);
        for (int p = 0; p < npix; p++) begin
            int x;
            int y;
            x = p % W;
            y = p / W;
            drive_px(fcol[(y/TP)*COLS + x/TP], sof0 && (p == 0));
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_left", exp_q.size(), 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int r0;
        checks     = 0;
        errors     = 0;
        rec_seen   = 0;
        mon_en     = 0;
        mx         = 0;
        my         = 0;
        exp_err    = 0;
        rst        = 1'b1;
        px_valid   = 1'b0;
        px_sof     = 1'b0;
        px_color   = 24'h0;
        tile_ready = 1'b1;
        for (int i = 0; i < COLS*ROWS; i++) fcol[i] = ref_col[i];

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_px_ready", px_ready, 1);
        chk("rst_tile_valid", tile_valid, 0);
        chk("rst_tile_idx", tile_idx, 0);
        chk("rst_tile_count", tile_count, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_sync_err", sync_err, 0);
        chk("rst_err_cnt", err_cnt, 0);
        @(negedge clk);
        rst    = 1'b0;
        mon_en = 1;
        @(posedge clk);
        #1;

        // All nine count colours plus gray, first pixel without px_sof
        drive_frame(NPIX, 0);
        drain();

        // Backpressure: the stream stalls, then delivers all records in order
        r0 = rec_seen;
        tile_ready = 1'b0;
        fork
            drive_frame(NPIX, 1);
            begin
                repeat (300) @(posedge clk);
                #1;
                tile_ready = 1'b1;
            end
        join
        drain();
        chk("stall_records", rec_seen - r0, COLS*ROWS);

        // Unknown colour on tile 1
        fcol[1] = 24'h123456;
        drive_frame(NPIX, 1);
        drain();
        chk("err_cnt_one", err_cnt, 1);
        fcol[1] = ref_col[1];

        // px_sof at pixel 20 of a frame
        drive_frame(20, 0);
        drive_frame(NPIX, 1);
        drain();

        // Reset with two records queued
        tile_ready = 1'b0;
        drive_frame(47, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_tile_valid", tile_valid, 0);
        chk("midrst_px_ready", px_ready, 1);
        chk("midrst_err_cnt", err_cnt, 0);
        exp_q.delete();
        mx      = 0;
        my      = 0;
        exp_err = 0;
        @(negedge clk);
        rst        = 1'b0;
        tile_ready = 1'b1;
        @(posedge clk);
        #1;
        drive_frame(NPIX, 0);
        drain();

        // Saturation: 30 frames with every tile unknown, 300 bad samples
        for (int i = 0; i < COLS*ROWS; i++) fcol[i] = 24'h123456 + 24'(i);
        for (int f = 0; f < 30; f++) drive_frame(NPIX, 0);
        drain();
        chk("err_cnt_sat", err_cnt, 255);

        // Random valid colours after saturation still decode correctly
        for (int i = 0; i < COLS*ROWS; i++) fcol[i] = ref_col[$urandom_range(COLS*ROWS-1, 0)];
        drive_frame(NPIX, 1);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
